mem_io_responder: RTL and testbench

//  Target side of the CPU byte-wide memory bus (addr/data-out/wr in, data-in out). Serves a 128KB

---
 rtl/mem_io_responder_if.sv | 24 ++
 rtl/mem_io_responder.sv | 197 +++++++++++++++++++
 tb/tb_mem_io_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// CPU byte-wide memory bus between the CPU (master) and the memory/I-O responder (slave).
interface mem_io_responder_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (
    output cpu_a,
    output cpu_dout,
    output cpu_wr,
    input  cpu_din,
    input  io_buffer_full
  );

  modport slave (
    input  cpu_a,
    input  cpu_dout,
    input  cpu_wr,
    output cpu_din,
    output io_buffer_full
  );
endinterface

// File: rtl/mem_io_responder.sv
// Target side of the CPU byte bus: byte RAM with one-cycle read latency plus an I/O window
// (addr[17:16]==2'b11) holding UART TX FIFO, UART RX pop, free-running cycle counter with
// a 32-bit read snapshot, and the program-stop sequencer.
module mem_io_responder #(
  parameter int RAM_AW = 17,
  parameter int TXF_AW = 3
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  mem_io_responder_if.slave        bus,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_pop,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic                     program_done
);

  localparam int DEPTH = 1 << TXF_AW;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STOP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Storage
  logic [7:0]        mem [2**RAM_AW];
  logic [7:0]        fifo_mem [DEPTH];

  // Registers and next-state values
  state_t            state_q, state_d;
  logic [7:0]        cpu_din_q, cpu_din_d;
  logic [31:0]       counter_q, counter_d;
  logic [31:0]       snap_q, snap_d;
  logic [TXF_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TXF_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TXF_AW:0]   count_q, count_d;

  // Decode
  logic              active;
  logic              is_io;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        reg_sel;
  logic              ram_wr, ram_rd, io_rd, io_wr;
  logic [7:0]        io_rdata;
  logic              fifo_full, fifo_pop, push_req, push_ok, stop_req;
  logic [7:0]        push_data;
  logic              unused_addr;

  assign active      = rdy_in && !rst_in;
  assign is_io       = (bus.cpu_a[17:16] == 2'b11);
  assign ram_idx     = bus.cpu_a[RAM_AW-1:0];
  assign reg_sel     = bus.cpu_a[2:0];
  assign unused_addr = ^bus.cpu_a;

  assign ram_wr = active && !is_io &&  bus.cpu_wr;
  assign ram_rd = active && !is_io && !bus.cpu_wr;
  assign io_rd  = active &&  is_io && !bus.cpu_wr;
  assign io_wr  = active &&  is_io &&  bus.cpu_wr;

  // I/O read mux; bytes 1..3 of the counter come from the snapshot taken at reg 4 so a
  // four-byte read sequence yields one coherent 32-bit value.
  always_comb begin
    io_rdata = 8'h00;
    case (reg_sel)
      3'd0:    io_rdata = rx_valid ? rx_data : 8'h00;
      3'd4:    io_rdata = counter_q[7:0];
      3'd5:    io_rdata = snap_q[15:8];
      3'd6:    io_rdata = snap_q[23:16];
      3'd7:    io_rdata = snap_q[31:24];
      default: io_rdata = 8'h00;
    endcase
  end

  // RX consume strobe: only while the RX register is being read and a byte is waiting.
  assign rx_pop = io_rd && (reg_sel == 3'd0) && rx_valid;

  // TX FIFO push/pop qualification. Reg 4 pushes a 0x00 terminator that bypasses the
  // zero filter; pushes are accepted only in RUN. A full FIFO still accepts a push when
  // the head leaves in the same cycle.
  assign fifo_full = (count_q == (TXF_AW+1)'(DEPTH));
  assign fifo_pop  = (count_q != '0) && tx_ready;
  assign stop_req  = io_wr && (state_q == ST_RUN) && (reg_sel == 3'd4);
  assign push_req  = io_wr && (state_q == ST_RUN) &&
                     (((reg_sel == 3'd0) && (bus.cpu_dout != 8'h00)) || (reg_sel == 3'd4));
  assign push_data = (reg_sel == 3'd4) ? 8'h00 : bus.cpu_dout;
  assign push_ok   = push_req && (!fifo_full || fifo_pop);

  assign bus.io_buffer_full = fifo_full;
  assign bus.cpu_din        = cpu_din_q;
  assign tx_valid           = (count_q != '0);
  assign tx_data            = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;

  // Next-state for read data, counter, snapshot and FIFO bookkeeping.
  always_comb begin
    cpu_din_d = cpu_din_q;
    counter_d = counter_q;
    snap_d    = snap_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (active) begin
      counter_d = counter_q + 32'd1;
    end
    if (io_rd) begin
      cpu_din_d = io_rdata;
      if (reg_sel == 3'd4) begin
        snap_d = counter_q;
      end
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + TXF_AW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + TXF_AW'(1);
    end
    case ({push_ok, fifo_pop})
      2'b10:   count_d = count_q + (TXF_AW+1)'(1);
      2'b01:   count_d = count_q - (TXF_AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control/state registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      counter_q <= '0;
      snap_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      counter_q <= counter_d;
      snap_q    <= snap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Read-data register: RAM reads take the array output, I/O reads take the I/O mux.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din_q <= 8'h00;
    end else if (ram_rd) begin
      cpu_din_q <= mem[ram_idx];
    end else begin
      cpu_din_q <= cpu_din_d;
    end
  end

  // RAM write port; contents are not reset.
  always_ff @(posedge clk_in) begin
    if (ram_wr) begin
      mem[ram_idx] <= bus.cpu_dout;
    end
  end

  // FIFO data storage; only pointers/count carry reset.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  // Stop sequencer state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop sequencer next state: RUN -> STOP on the stop write, STOP -> DONE once drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (stop_req) state_d = ST_STOP;
      ST_STOP: if (count_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // Stop sequencer outputs.
  always_comb begin
    program_done = 1'b0;
    if (state_q == ST_DONE) begin
      program_done = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rdy_in;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       program_done;

  mem_io_responder_if bus ();

  mem_io_responder #(.RAM_AW(17), .TXF_AW(3)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .bus          (bus.slave),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_pop       (rx_pop),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .program_done (program_done)
  );

  always #5 clk_in = ~clk_in;

  int         total = 0;
  int         bad   = 0;
  int         pops  = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp3 [9];

  // Capture every byte the UART accepts and every RX pop.
  always @(posedge clk_in) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (rx_pop) pops++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
    bus.cpu_a    = a;
    bus.cpu_dout = d;
    bus.cpu_wr   = 1'b1;
    tick();
  endtask

  task automatic bus_rd(input logic [31:0] a);
    bus.cpu_a  = a;
    bus.cpu_wr = 1'b0;
    tick();
  endtask

  task automatic idle(input int n);
    bus.cpu_a  = 32'h0000_0100;
    bus.cpu_wr = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] qat(input int i);
    return (tx_q.size() > i) ? tx_q[i] : 8'hEE;
  endfunction

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    bus.cpu_a = 32'h0; bus.cpu_dout = 8'h00; bus.cpu_wr = 1'b0;
    tick(); tick();
    chk("rst_din",  {24'h0, bus.cpu_din}, 32'h00);
    chk("rst_pop",  {31'h0, rx_pop}, 32'h0);
    chk("rst_txv",  {31'h0, tx_valid}, 32'h0);
    chk("rst_txd",  {24'h0, tx_data}, 32'h00);
    chk("rst_full", {31'h0, bus.io_buffer_full}, 32'h0);
    chk("rst_done", {31'h0, program_done}, 32'h0);
    rst_in = 1'b0;

    // RAM write then read-back with one-cycle latency
    bus_wr(32'h0001_0010, 8'hA5);
    bus_rd(32'h0001_0010);
    chk("ram_10", {24'h0, bus.cpu_din}, 32'hA5);
    bus_wr(32'h0001_FFFF, 8'h5A);
    bus_rd(32'h0001_FFFF);
    chk("ram_top", {24'h0, bus.cpu_din}, 32'h5A);
    bus_rd(32'h0001_0010);
    chk("ram_10b", {24'h0, bus.cpu_din}, 32'hA5);

    // TX zero filter
    tx_ready = 1'b1;
    tx_q.delete();
    bus_wr(32'h0003_0000, 8'h41);
    bus_wr(32'h0003_0000, 8'h00);
    bus_wr(32'h0003_0000, 8'h42);
    idle(4);
    chk("tx2_n",  tx_q.size(), 32'd2);
    chk("tx2_0",  {24'h0, qat(0)}, 32'h41);
    chk("tx2_1",  {24'h0, qat(1)}, 32'h42);

    // FIFO full, drop on overflow, simultaneous push/pop while full
    tx_ready = 1'b0;
    tx_q.delete();
    for (int i = 1; i <= 7; i++) bus_wr(32'h0003_0000, 8'(i));
    chk("full7", {31'h0, bus.io_buffer_full}, 32'h0);
    bus_wr(32'h0003_0000, 8'h08);
    chk("full8", {31'h0, bus.io_buffer_full}, 32'h1);
    chk("head8", {24'h0, tx_data}, 32'h01);
    bus_wr(32'h0003_0000, 8'h09);
    chk("full9", {31'h0, bus.io_buffer_full}, 32'h1);
    tx_ready = 1'b1;
    bus_wr(32'h0003_0000, 8'h0A);
    chk("full_pp", {31'h0, bus.io_buffer_full}, 32'h1);
    chk("head_pp", {24'h0, tx_data}, 32'h02);
    idle(12);
    chk("full_drained", {31'h0, bus.io_buffer_full}, 32'h0);
    chk("tx3_n", tx_q.size(), 32'd9);
    exp3 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
    for (int i = 0; i < 9; i++) chk($sformatf("tx3_%0d", i), {24'h0, qat(i)}, {24'h0, exp3[i]});

    // Cycle counter snapshot and rdy_in freeze
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    idle(32'h1FF);
    bus_rd(32'h0003_0004);
    chk("cnt_b0", {24'h0, bus.cpu_din}, 32'hFF);
    bus_rd(32'h0003_0005);
    chk("cnt_b1", {24'h0, bus.cpu_din}, 32'h01);
    bus_rd(32'h0003_0006);
    chk("cnt_b2", {24'h0, bus.cpu_din}, 32'h00);
    bus_rd(32'h0003_0007);
    chk("cnt_b3", {24'h0, bus.cpu_din}, 32'h00);
    rdy_in = 1'b0;
    bus.cpu_a = 32'h0003_0004;
    for (int i = 0; i < 5; i++) tick();
    chk("din_hold", {24'h0, bus.cpu_din}, 32'h00);
    rdy_in = 1'b1;
    bus_rd(32'h0003_0004);
    chk("cnt_frz0", {24'h0, bus.cpu_din}, 32'h03);
    bus_rd(32'h0003_0005);
    chk("cnt_frz1", {24'h0, bus.cpu_din}, 32'h02);

    // RX read with and without a pending byte
    pops = 0;
    rx_valid = 1'b0;
    bus.cpu_a = 32'h0003_0000; bus.cpu_wr = 1'b0;
    #1;
    chk("rx_nopop", {31'h0, rx_pop}, 32'h0);
    tick();
    chk("rx_empty", {24'h0, bus.cpu_din}, 32'h00);
    rx_valid = 1'b1; rx_data = 8'h37;
    #1;
    chk("rx_pop", {31'h0, rx_pop}, 32'h1);
    tick();
    chk("rx_data", {24'h0, bus.cpu_din}, 32'h37);
    bus.cpu_a = 32'h0000_0100;
    #1;
    chk("rx_pop_ram", {31'h0, rx_pop}, 32'h0);
    rx_valid = 1'b0;
    chk("rx_npops", pops, 32'd1);

    // Program stop sequencing
    tx_ready = 1'b0;
    tx_q.delete();
    bus_wr(32'h0003_0000, 8'h48);
    bus_wr(32'h0003_0004, 8'h77);
    idle(2);
    chk("stop_done0", {31'h0, program_done}, 32'h0);
    chk("stop_head",  {24'h0, tx_data}, 32'h48);
    tx_ready = 1'b1;
    idle(4);
    chk("stop_done1", {31'h0, program_done}, 32'h1);
    chk("stop_n",     tx_q.size(), 32'd2);
    chk("stop_0",     {24'h0, qat(0)}, 32'h48);
    chk("stop_1",     {24'h0, qat(1)}, 32'h00);
    bus_wr(32'h0003_0000, 8'h55);
    idle(3);
    chk("done_ign_n", tx_q.size(), 32'd2);
    chk("done_txv",   {31'h0, tx_valid}, 32'h0);
    chk("done_hold",  {31'h0, program_done}, 32'h1);

    // Reset while stopped with bytes pending
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    tx_ready = 1'b0;
    bus_wr(32'h0003_0000, 8'h5A);
    bus_wr(32'h0003_0004, 8'h00);
    idle(1);
    chk("rs_txv1", {31'h0, tx_valid}, 32'h1);
    chk("rs_done0", {31'h0, program_done}, 32'h0);
    rst_in = 1'b1;
    tick();
    chk("rs_txv0", {31'h0, tx_valid}, 32'h0);
    chk("rs_txd0", {24'h0, tx_data}, 32'h00);
    rst_in = 1'b0;
    idle(2);
    chk("rs_run", {31'h0, program_done}, 32'h0);
    bus_wr(32'h0003_0000, 8'h31);
    chk("rs_push", {24'h0, tx_data}, 32'h31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
